// File: rtl/inst_fetch_unit.sv
// ----------------------------------------------------------------------------
// inst_fetch_unit
//
// Front end of the single-issue RISC-V core. Holds the fetch PC, requests
// 32-bit instruction words from instruction memory over a req/ack interface,
// buffers them in a small FIFO and presents {inst, inst_pc} to the decoder
// with a valid/ready handshake. Branch/jump redirects flush the queue and
// discard any wrong-path fetch that is still in flight.
//
// Optional feature (macro IFU_BYPASS_EN): with the queue empty, an accepted
// memory word is presented to the decoder in the ack cycle itself and is only
// written into the queue if the decoder does not take it.
//
// Ports:
//   clk            in   core clock, rising edge
//   rst            in   synchronous active-high reset
//   imem_ren       out  fetch request, held with imem_addr until imem_ack
//   imem_addr      out  word-aligned fetch address
//   imem_ack       in   memory completion, imem_rdata valid this cycle
//   imem_rdata     in   fetched instruction word
//   inst_valid     out  queue head valid toward decoder
//   inst           out  queue head instruction
//   inst_pc        out  PC of queue head
//   inst_ready     in   decoder accepts head this cycle
//   redirect_valid in   taken branch/jump pulse
//   redirect_pc    in   new fetch target (low two bits ignored)
// ----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int unsigned     BITS     = 32,
    parameter logic [BITS-1:0] RESET_PC = '0,
    parameter int unsigned     Q_DEPTH  = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_ren,
    output logic [BITS-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [BITS-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [BITS-1:0] inst,
    output logic [BITS-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [BITS-1:0] redirect_pc
);

    localparam int unsigned     PtrW     = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int unsigned     CntW     = $clog2(Q_DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Q_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrop
    } state_e;

    state_e          state_q;
    logic            imem_ren_q;
    logic [BITS-1:0] imem_addr_q;
    logic [BITS-1:0] fetch_pc_q;

    logic [BITS-1:0] q_inst_q [Q_DEPTH];
    logic [BITS-1:0] q_pc_q   [Q_DEPTH];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] count_q;

    logic            head_valid;
    logic            pop;
    logic            accept;
    logic            push;
    logic            bypass_take;
    logic [CntW-1:0] count_after_pop;
    logic [BITS-1:0] redirect_tgt;

    assign redirect_tgt    = redirect_pc & ~BITS'(3);
    assign head_valid      = (count_q != '0);
    assign pop             = head_valid & inst_ready;
    // A live (non-dropped) fetch completes and is not cancelled by a redirect.
    assign accept          = (state_q == StReq) & imem_ack & ~redirect_valid;
    assign push            = accept & ~bypass_take;
    assign count_after_pop = count_q - CntW'(pop);

`ifdef IFU_BYPASS_EN
    logic bypass_hit;

    assign bypass_hit  = accept & ~head_valid;
    assign bypass_take = bypass_hit & inst_ready;
    assign inst_valid  = head_valid | bypass_hit;
    assign inst        = bypass_hit ? imem_rdata : q_inst_q[rd_ptr_q];
    assign inst_pc     = bypass_hit ? fetch_pc_q : q_pc_q[rd_ptr_q];
`else
    assign bypass_take = 1'b0;
    assign inst_valid  = head_valid;
    assign inst        = q_inst_q[rd_ptr_q];
    assign inst_pc     = q_pc_q[rd_ptr_q];
`endif

    assign imem_ren  = imem_ren_q;
    assign imem_addr = imem_addr_q;

    // Instruction queue. A redirect flushes after any same-cycle pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < Q_DEPTH; i++) begin
                q_inst_q[i] <= '0;
                q_pc_q[i]   <= '0;
            end
        end else begin
            if (push) begin
                q_inst_q[wr_ptr_q] <= imem_rdata;
                q_pc_q[wr_ptr_q]   <= fetch_pc_q;
            end
            if (redirect_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
                count_q <= count_q + CntW'(push) - CntW'(pop);
            end
        end
    end

    // Fetch FSM. imem_ren/imem_addr are registered alongside the state so the
    // request stays stable, including the old address while draining a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            imem_ren_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
        end else begin
            if (redirect_valid) begin
                fetch_pc_q <= redirect_tgt;
            end else if (accept) begin
                fetch_pc_q <= fetch_pc_q + BITS'(4);
            end

            case (state_q)
                StIdle: begin
                    // Only one request is ever outstanding, so in IDLE a slot
                    // is free exactly when the post-pop count is below depth.
                    if (!redirect_valid && (count_after_pop < DepthCnt)) begin
                        state_q     <= StReq;
                        imem_ren_q  <= 1'b1;
                        imem_addr_q <= fetch_pc_q;
                    end
                end
                StReq: begin
                    if (imem_ack) begin
                        state_q    <= StIdle;
                        imem_ren_q <= 1'b0;
                    end else if (redirect_valid) begin
                        state_q <= StDrop;
                    end
                end
                StDrop: begin
                    if (imem_ack) begin
                        state_q    <= StIdle;
                        imem_ren_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    imem_ren_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized scoreboard bench for inst_fetch_unit. The reference model tracks
// the architectural fetch stream (next PC, +4 per accepted word, restart at
// the aligned target on redirect) and the stream of words the decoder must see.
`timescale 1ns/1ps
module tb_inst_fetch_unit;

    localparam int unsigned BITS     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned Q_DEPTH  = 2;
`ifdef IFU_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .BITS     (BITS),
        .RESET_PC (RESET_PC),
        .Q_DEPTH  (Q_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_ren       (imem_ren),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        int          avail;
    } item_t;

    item_t       sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          n_hs = 0;
    bit          started = 0;
    bit          was_rst = 0;
    bit          flush_pend = 0;
    bit          stale = 0;
    bit          req_active = 0;
    bit          acked_prev = 0;
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] req_addr = '0;
    int          lat_left = 0;
    logic        exp_v;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %0s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) was_rst <= rst;

    // Monitor: compares decoder-side outputs against the scoreboard.
    always @(negedge clk) begin
        if (started) begin
            if (was_rst) begin
                chk("reset_imem_ren", imem_ren, 0);
                chk("reset_imem_addr", imem_addr, RESET_PC);
                chk("reset_inst_valid", inst_valid, 0);
                chk("reset_inst", inst, 0);
                chk("reset_inst_pc", inst_pc, 0);
            end else begin
                exp_v = (sb.size() > 0) && (sb[0].avail <= cyc);
                chk("inst_valid", inst_valid, exp_v);
                if (exp_v && inst_valid) begin
                    chk("inst_word", inst, sb[0].word);
                    chk("inst_pc", inst_pc, sb[0].pc);
                end
                if (inst_valid && inst_ready && sb.size() > 0) begin
                    void'(sb.pop_front());
                    n_hs++;
                end
            end
        end
    end

    // One clock of stimulus plus memory model. mode: 0 random, 1 redirect on a
    // fresh request, 2 redirect together with an ack, 3 reset while imem_ren=1.
    task automatic step(input int rdy_pct, input int redir_pct, input int min_lat,
                        input int max_lat, input int mode, output bit hit);
        bit          ack;
        bit          spur;
        bit          redir;
        bit          new_req;
        bit          prev_rst;
        bit          stale_this;
        logic [31:0] tgt;
        hit = 0;
        new_req = 0;
        stale_this = 0;
        @(posedge clk);
        #1;
        cyc++;
        prev_rst = rst;
        if (flush_pend) begin
            sb.delete();
            flush_pend = 0;
        end
        if (prev_rst) begin
            sb.delete();
            model_pc = RESET_PC;
            stale = 0;
            req_active = 0;
            acked_prev = 0;
        end else begin
            if (acked_prev) chk("ren_gap_after_ack", imem_ren, 0);
            new_req = imem_ren && !req_active;
            if (new_req) begin
                chk("req_addr", imem_addr, model_pc);
                chk("req_slot_free", sb.size() < Q_DEPTH, 1);
                req_active = 1;
                req_addr = imem_addr;
                lat_left = $urandom_range(max_lat, min_lat);
            end else if (req_active) begin
                chk("req_held", imem_ren, 1);
                chk("req_addr_stable", imem_addr, req_addr);
                if (!imem_ren) req_active = 0;
            end
        end

        ack = 0;
        spur = 0;
        if (req_active) begin
            if (lat_left == 0) ack = 1;
            else lat_left--;
        end else begin
            spur = ($urandom_range(9, 0) == 0);
        end
        redir = ($urandom_range(99, 0) < redir_pct);
        tgt = $urandom_range(32'h0FFF, 0);
        if ($urandom_range(3, 0) == 0) tgt = $urandom;
        case (mode)
            1: begin redir = new_req && !ack; tgt = 32'h0000_0100; end
            2: begin redir = ack; tgt = 32'h0000_0203; end
            default: ;
        endcase
        if (mode == 1 || mode == 2) hit = redir;
        rst = 0;
        if (mode == 3 && imem_ren && !prev_rst) begin
            rst = 1;
            hit = 1;
        end

        imem_ack       = ack || spur;
        imem_rdata     = ack ? mem_word(req_addr) : $urandom;
        redirect_valid = redir;
        redirect_pc    = tgt;
        inst_ready     = ($urandom_range(99, 0) < rdy_pct);

        if (ack) begin
            req_active = 0;
            stale_this = stale;
            stale = 0;
        end
        acked_prev = ack;
        if (ack && !redir && !stale_this) begin
            sb.push_back('{mem_word(model_pc), model_pc, cyc + LAT});
            model_pc = model_pc + 32'd4;
        end
        if (redir) begin
            model_pc = tgt & ~32'h3;
            flush_pend = 1;
            if (req_active) stale = 1;
        end
    endtask

    initial begin
        bit hit;
        int tries;
        repeat (3) @(posedge clk);
        #1;
        started = 1;

        // Streaming, single-cycle-late memory, decoder always ready.
        repeat (30) step(100, 0, 1, 1, 0, hit);

        // Backpressure: queue fills to depth and fetching stops.
        repeat (10) step(0, 0, 1, 1, 0, hit);
        @(negedge clk);
        chk("full_ren_idle", imem_ren, 0);
        chk("full_inst_valid", inst_valid, 1);
        repeat (10) step(100, 0, 1, 1, 0, hit);

        // Redirect to 0x100 while a request is pending, ack three cycles later.
        hit = 0;
        tries = 0;
        while (!hit && tries < 50) begin
            step(100, 0, 3, 3, 1, hit);
            tries++;
        end
        chk("redirect_pending_issued", hit, 1);
        repeat (20) step(100, 0, 1, 1, 0, hit);

        // Redirect to 0x203 in the same cycle as an ack.
        hit = 0;
        tries = 0;
        while (!hit && tries < 50) begin
            step(100, 0, 1, 1, 2, hit);
            tries++;
        end
        chk("redirect_with_ack_issued", hit, 1);
        repeat (20) step(100, 0, 0, 0, 0, hit);

        // Random mix of latency, backpressure and redirects.
        repeat (2000) step(60, 5, 0, 3, 0, hit);

        // Reset while a fetch is outstanding.
        hit = 0;
        tries = 0;
        while (!hit && tries < 50) begin
            step(50, 0, 2, 3, 3, hit);
            tries++;
        end
        chk("reset_mid_fetch_issued", hit, 1);
        repeat (20) step(100, 0, 0, 2, 0, hit);

        repeat (1000) step(30, 3, 0, 3, 0, hit);
        repeat (10) step(100, 0, 0, 0, 0, hit);
        @(negedge clk);
        chk("progress_handshakes", n_hs > 200, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
